// File: rtl/async_fifo_pkg.sv
// Shared definitions for the asynchronous FIFO: default widths, pointer type,
// read-side output state encoding and Gray/binary conversion helpers.
package async_fifo_pkg;

  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 8;

  // Pointers carry one extra wrap bit beyond the RAM address.
  typedef logic [ADDR_W_DEF:0] ptr_t;

  // Output register state; the encoding doubles as the dout_valid flag.
  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_VALID = 1'b1
  } out_state_e;

  function automatic ptr_t bin2gray(input ptr_t bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic ptr_t gray2bin(input ptr_t gray);
    ptr_t bin;
    bin = '0;
    for (int i = 0; i <= ADDR_W_DEF; i++) begin
      bin[i] = ^(gray >> i);
    end
    return bin;
  endfunction

endpackage

// File: rtl/async_fifo_rd_ctrl_gray_to_bin.sv
// Combinational Gray-to-binary decoder of arbitrary width.
module gray_to_bin #(
  parameter int W = 5
) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin
);

  // Each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    // NOTE: every combinational output gets a default before any conditional
    // or loop assignment, so no path can leave it unassigned and infer a latch.
    bin = '0;
    for (int i = 0; i < W; i++) begin
      bin[i] = ^(gray >> i);
    end
  end

endmodule

// File: rtl/async_fifo_rd_ctrl.sv
// Read-side controller of the asynchronous FIFO (destination clock domain).
// Owns the read pointer, drives the RAM read port and presents a
// first-word-fall-through valid/ready stream plus pessimistic status.
module async_fifo_rd_ctrl
  import async_fifo_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int AE_THRESH = 2
) (
  input  logic              dest_clk,
  input  logic              rst_n,
  input  logic [ADDR_W:0]   wr_ptr_gray_sync,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic [ADDR_W:0]   rd_ptr_gray,
  output logic              empty,
  output logic              almost_empty,
  output logic [ADDR_W:0]   rd_count
);

  localparam int PTR_W = ADDR_W + 1;

  logic [PTR_W-1:0] wr_bin_sync;
  logic [PTR_W-1:0] rd_bin_q, rd_bin_d;
  logic [PTR_W-1:0] rd_gray_q, rd_gray_d;
  logic [PTR_W-1:0] rd_count_q, rd_count_d;
  logic             empty_q, empty_d;
  logic             almost_empty_q, almost_empty_d;
  out_state_e       state_q, state_d;

  gray_to_bin #(
    .W (PTR_W)
  ) u_wr_g2b (
    .gray (wr_ptr_gray_sync),
    .bin  (wr_bin_sync)
  );

  // Read strobe, next pointer and status computed against the synced write pointer.
  always_comb begin
    mem_rd_en      = !empty_q && ((state_q == OUT_EMPTY) || dout_ready);
    rd_bin_d       = rd_bin_q + PTR_W'(mem_rd_en);
    rd_gray_d      = rd_bin_d ^ (rd_bin_d >> 1);
    empty_d        = (rd_gray_d == wr_ptr_gray_sync);
    // Modular subtraction handles any write-pointer jump and pointer wrap.
    rd_count_d     = wr_bin_sync - rd_bin_d;
    almost_empty_d = (rd_count_d <= PTR_W'(AE_THRESH));
  end

  // Output stage next state: fills on a read, empties when consumed without refill.
  always_comb begin
    state_d = state_q;
    case (state_q)
      OUT_EMPTY: if (mem_rd_en) state_d = OUT_VALID;
      OUT_VALID: if (dout_ready && !mem_rd_en) state_d = OUT_EMPTY;
      default:   state_d = OUT_EMPTY;
    endcase
  end

  // Pointer, status and output-state registers; reset clears immediately.
  always_ff @(posedge dest_clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_bin_q       <= '0;
      rd_gray_q      <= '0;
      rd_count_q     <= '0;
      empty_q        <= 1'b1;
      almost_empty_q <= 1'b1;
      state_q        <= OUT_EMPTY;
    end else begin
      // NOTE: state updates use non-blocking assignment so every register
      // samples pre-edge values regardless of statement or process order.
      rd_bin_q       <= rd_bin_d;
      rd_gray_q      <= rd_gray_d;
      rd_count_q     <= rd_count_d;
      empty_q        <= empty_d;
      almost_empty_q <= almost_empty_d;
      state_q        <= state_d;
    end
  end

  assign mem_rd_addr  = rd_bin_q[ADDR_W-1:0];
  assign dout         = mem_rd_data;
  assign dout_valid   = (state_q == OUT_VALID);
  assign rd_ptr_gray  = rd_gray_q;
  assign empty        = empty_q;
  assign almost_empty = almost_empty_q;
  assign rd_count     = rd_count_q;

endmodule

// File: tb/tb_async_fifo_rd_ctrl.sv
// Self-checking bench for async_fifo_rd_ctrl: a write-side stimulus with a
// RAM model, a transaction-count reference model and a data scoreboard.
module tb_async_fifo_rd_ctrl;
  import async_fifo_pkg::*;

  localparam int AW = 4;
  localparam int DW = 8;
  localparam int DEPTH = 16;
  localparam int AE = 2;

  logic          dest_clk = 1'b0;
  logic          rst_n;
  logic [AW:0]   wr_ptr_gray_sync;
  logic          mem_rd_en;
  logic [AW-1:0] mem_rd_addr;
  logic [DW-1:0] mem_rd_data = '0;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          dout_ready;
  logic [AW:0]   rd_ptr_gray;
  logic          empty;
  logic          almost_empty;
  logic [AW:0]   rd_count;

  int checks = 0;
  int errors = 0;

  // Write side: total words ever written, exported as a Gray pointer.
  int            wr_total = 0;
  logic [DW-1:0] ram [DEPTH];
  logic [DW-1:0] exp_q [$];

  // Reference model in terms of word counts.
  int   m_fetched = 0;
  int   m_count = 0;
  logic m_empty = 1'b1;
  logic m_valid = 1'b0;
  logic m_rd;

  async_fifo_rd_ctrl #(
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .AE_THRESH (AE)
  ) dut (
    .dest_clk         (dest_clk),
    .rst_n            (rst_n),
    .wr_ptr_gray_sync (wr_ptr_gray_sync),
    .mem_rd_en        (mem_rd_en),
    .mem_rd_addr      (mem_rd_addr),
    .mem_rd_data      (mem_rd_data),
    .dout             (dout),
    .dout_valid       (dout_valid),
    .dout_ready       (dout_ready),
    .rd_ptr_gray      (rd_ptr_gray),
    .empty            (empty),
    .almost_empty     (almost_empty),
    .rd_count         (rd_count)
  );

  initial forever #5 dest_clk = ~dest_clk;

  assign wr_ptr_gray_sync = bin2gray(ptr_t'(wr_total[AW:0]));

  // Synchronous RAM read port.
  always @(posedge dest_clk) begin
    if (mem_rd_en) mem_rd_data <= ram[mem_rd_addr];
  end

  // A word is fetched whenever storage is non-empty and the output slot is free or being consumed.
  assign m_rd = !m_empty && (!m_valid || dout_ready);

  always @(posedge dest_clk or negedge rst_n) begin
    if (!rst_n) begin
      m_fetched <= 0;
      m_count   <= 0;
      m_empty   <= 1'b1;
      m_valid   <= 1'b0;
    end else begin
      m_fetched <= m_fetched + int'(m_rd);
      m_count   <= wr_total - (m_fetched + int'(m_rd));
      m_empty   <= (wr_total - (m_fetched + int'(m_rd))) == 0;
      m_valid   <= m_rd || (m_valid && !dout_ready);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compares status every cycle and pops the scoreboard on each consumed word.
  always @(negedge dest_clk) begin
    if (rst_n) begin
      check("dout_valid",   32'(dout_valid),   32'(m_valid));
      check("empty",        32'(empty),        32'(m_empty));
      check("almost_empty", 32'(almost_empty), 32'(m_count <= AE));
      check("rd_count",     32'(rd_count),     32'(m_count));
      check("rd_ptr_gray",  32'(rd_ptr_gray),  32'(bin2gray(ptr_t'(m_fetched[AW:0]))));
      check("mem_rd_en",    32'(mem_rd_en),    32'(m_rd));
      check("mem_rd_addr",  32'(mem_rd_addr),  32'(m_fetched[AW-1:0]));
      if (dout_valid && dout_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL dout_unexpected: actual=word consumed required=no word pending (t=%0t)", $time);
        end else begin
          check("dout", 32'(dout), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  task automatic step();
    @(posedge dest_clk);
    #1;
  endtask

  task automatic write_words(input int n);
    logic [DW-1:0] d;
    for (int i = 0; i < n; i++) begin
      d = DW'($urandom);
      ram[wr_total % DEPTH] = d;
      exp_q.push_back(d);
      wr_total++;
    end
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    dout_ready = 1'b1;
    while (!(m_empty && !m_valid && wr_total == m_fetched) && n < 200) begin
      step();
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout_%s: actual=not drained required=drained within 200 cycles", tag);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual=still running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int space;
    logic [DW-1:0] held;
    logic [AW:0]   gray_held;

    // Reset values.
    rst_n = 1'b0;
    dout_ready = 1'b0;
    repeat (3) step();
    check("rst_dout_valid",   32'(dout_valid),   32'd0);
    check("rst_empty",        32'(empty),        32'd1);
    check("rst_almost_empty", 32'(almost_empty), 32'd1);
    check("rst_rd_ptr_gray",  32'(rd_ptr_gray),  32'd0);
    check("rst_rd_count",     32'(rd_count),     32'd0);
    check("rst_mem_rd_en",    32'(mem_rd_en),    32'd0);
    check("rst_mem_rd_addr",  32'(mem_rd_addr),  32'd0);
    rst_n = 1'b1;
    step();

    // Fill with three words then drain.
    dout_ready = 1'b1;
    write_words(3);
    step();
    check("fill_empty",    32'(empty),    32'd0);
    check("fill_rd_count", 32'(rd_count), 32'd3);
    drain("fill");
    check("fill_final_gray",  32'(rd_ptr_gray), 32'b00010);
    check("fill_final_empty", 32'(empty),       32'd1);

    // Backpressure with four words left in storage.
    dout_ready = 1'b0;
    write_words(5);
    step();
    step();
    check("bp_dout_valid", 32'(dout_valid), 32'd1);
    check("bp_rd_count",   32'(rd_count),   32'd4);
    held = dout;
    gray_held = rd_ptr_gray;
    repeat (5) begin
      step();
      check("bp_mem_rd_en",  32'(mem_rd_en),   32'd0);
      check("bp_dout_hold",  32'(dout),        32'(held));
      check("bp_gray_hold",  32'(rd_ptr_gray), 32'(gray_held));
    end
    drain("bp");

    // Stream up to 30 words total, then cross the pointer wrap.
    n = 0;
    while (wr_total < 30 && n < 200) begin
      space = DEPTH - (wr_total - m_fetched);
      space = (space < 3) ? space : 3;
      space = (space < 30 - wr_total) ? space : 30 - wr_total;
      write_words(space);
      step();
      n++;
    end
    drain("pre_wrap");
    check("wrap_start_gray", 32'(rd_ptr_gray), 32'b10001);
    write_words(3);
    step();
    check("wrap_addr0", 32'(mem_rd_addr), 32'd14);
    check("wrap_en0",   32'(mem_rd_en),   32'd1);
    step();
    check("wrap_gray1", 32'(rd_ptr_gray), 32'b10000);
    check("wrap_addr1", 32'(mem_rd_addr), 32'd15);
    step();
    check("wrap_gray2", 32'(rd_ptr_gray), 32'b00000);
    check("wrap_addr2", 32'(mem_rd_addr), 32'd0);
    step();
    check("wrap_gray3", 32'(rd_ptr_gray), 32'b00001);
    check("wrap_empty", 32'(empty),       32'd1);
    drain("wrap");

    // Full occupancy, then drain down to the almost-empty threshold.
    dout_ready = 1'b0;
    write_words(DEPTH);
    step();
    check("full_rd_count",     32'(rd_count),     32'd16);
    check("full_almost_empty", 32'(almost_empty), 32'd0);
    check("full_empty",        32'(empty),        32'd0);
    dout_ready = 1'b1;
    n = 0;
    while (m_count != AE && n < 100) begin
      step();
      n++;
    end
    check("ae_rd_count",     32'(rd_count),     32'(AE));
    check("ae_almost_empty", 32'(almost_empty), 32'd1);
    drain("full");

    // Reset asserted while a word is presented.
    dout_ready = 1'b0;
    write_words(4);
    step();
    step();
    check("pre_rst_dout_valid", 32'(dout_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    wr_total = 0;
    exp_q.delete();
    #1;
    check("mid_rst_dout_valid",   32'(dout_valid),   32'd0);
    check("mid_rst_empty",        32'(empty),        32'd1);
    check("mid_rst_almost_empty", 32'(almost_empty), 32'd1);
    check("mid_rst_rd_count",     32'(rd_count),     32'd0);
    check("mid_rst_rd_ptr_gray",  32'(rd_ptr_gray),  32'd0);
    check("mid_rst_mem_rd_en",    32'(mem_rd_en),    32'd0);
    check("mid_rst_mem_rd_addr",  32'(mem_rd_addr),  32'd0);
    step();
    step();
    rst_n = 1'b1;
    dout_ready = 1'b1;
    write_words(2);
    step();
    check("post_rst_addr", 32'(mem_rd_addr), 32'd0);
    check("post_rst_en",   32'(mem_rd_en),   32'd1);
    drain("post_rst");

    // Randomized bursts and backpressure, including multi-word pointer jumps.
    repeat (800) begin
      dout_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) == 0) begin
        space = DEPTH - (wr_total - m_fetched);
        n = $urandom_range(0, 4);
        if (n > space) n = space;
        write_words(n);
      end
      step();
    end
    drain("random");
    check("end_scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
